// File: rtl/rstgen_pkg.sv
// Shared types for the ordered reset sequencer.
// Holds the sequencer FSM state encoding.
// Combinational definitions only; no latency and no backpressure.
package rstgen_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    SEQ  = 2'd2,
    DONE = 2'd3
  } rstgen_state_e;

endpackage

// File: rtl/rstgen_sync.sv
// Asynchronously cleared NumRegs-deep reset synchroniser chain.
// sync_n rises NumRegs clk_i edges after rst_i is released.
// No backpressure; assertion of rst_i clears the chain immediately.
module rstgen_sync #(
  parameter int unsigned NumRegs = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sync_n
);

  logic [NumRegs-1:0] chain_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[NumRegs-2:0], 1'b1};
    end
  end

  assign sync_n = chain_q[NumRegs-1];

endmodule

// File: rtl/tc_clk_mux2.sv
// Technology cell: 2:1 glitch-tolerant mux used on reset and DFT paths.
// Purely combinational, zero latency; no backpressure.
// clk_sel_i=0 selects clk0_i, clk_sel_i=1 selects clk1_i.
module tc_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);

  assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/rstgen_seq.sv
// Ordered reset sequencer: hold all channels, then release them in index order (SW reset: RSTGEN_SEQ_SW_RESET_EN).
// Channel k released NumRegs+HoldCycles+k*GapCycles edges after reset; asserts asynchronously.
// No backpressure; a software request restarts the hold from the sampling edge.
module rstgen_seq
  import rstgen_pkg::*;
#(
  parameter int unsigned NumRegs    = 4,
  parameter int unsigned NumOut     = 3,
  parameter int unsigned HoldCycles = 16,
  parameter int unsigned GapCycles  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_mode_i,
  input  logic              rst_test_mode_ni,
  input  logic              sw_rst_req_i,
  output logic [NumOut-1:0] rst_no,
  output logic [NumOut-1:0] init_no,
  output logic              done_o
);

  localparam int unsigned CntMax = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = (NumOut > 1) ? $clog2(NumOut) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumOut - 1);

`ifndef COMMON_CELLS_ASSERTS_OFF
  initial begin
    if (NumRegs < 2)    $fatal(1, "rstgen_seq: NumRegs must be at least 2");
    if (NumOut < 1)     $fatal(1, "rstgen_seq: NumOut must be at least 1");
    if (HoldCycles < 1) $fatal(1, "rstgen_seq: HoldCycles must be at least 1");
    if (GapCycles < 1)  $fatal(1, "rstgen_seq: GapCycles must be at least 1");
  end
`endif

  logic rst_tm;
  logic rst_int;
  logic sync_n;
  logic sw_req;

  assign rst_tm = ~rst_test_mode_ni;

  tc_clk_mux2 i_rst_mux (
    .clk0_i    (rst_i),
    .clk1_i    (rst_tm),
    .clk_sel_i (test_mode_i),
    .clk_o     (rst_int)
  );

  rstgen_sync #(
    .NumRegs (NumRegs)
  ) i_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_int),
    .sync_n (sync_n)
  );

`ifdef RSTGEN_SEQ_SW_RESET_EN
  assign sw_req = sw_rst_req_i;
`else
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req_i;
  assign sw_req            = 1'b0;
`endif

  rstgen_state_e     state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [NumOut-1:0] rel_q;
  logic              done_q;

  // The edge that first sees sync_n=1 already counts as the first hold cycle.
  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      done_q  <= 1'b0;
    end else if (sw_req && (state_q != SYNC)) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        SYNC, HOLD: begin
          if ((state_q == HOLD) || sync_n) begin
            if (cnt_q == HoldLast) begin
              cnt_q    <= '0;
              rel_q[0] <= 1'b1;
              if (NumOut == 1) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= SEQ;
                idx_q   <= IdxW'(1);
              end
            end else begin
              cnt_q   <= cnt_q + CntW'(1);
              state_q <= HOLD;
            end
          end
        end
        SEQ: begin
          if (cnt_q == GapLast) begin
            cnt_q <= '0;
            rel_q <= rel_q | (NumOut'(1) << idx_q);
            if (idx_q == IdxLast) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  logic init_tm;
  assign init_tm = 1'b1;

  for (genvar k = 0; k < NumOut; k++) begin : g_out
    tc_clk_mux2 i_rst_out_mux (
      .clk0_i    (rel_q[k]),
      .clk1_i    (rst_test_mode_ni),
      .clk_sel_i (test_mode_i),
      .clk_o     (rst_no[k])
    );

    tc_clk_mux2 i_init_out_mux (
      .clk0_i    (rel_q[k]),
      .clk1_i    (init_tm),
      .clk_sel_i (test_mode_i),
      .clk_o     (init_no[k])
    );
  end

  assign done_o = done_q;

endmodule
